// File: rtl/conv_fp_widen.sv
// conv_fp_widen: widens a small IEEE-style float {sign, exponent, mantissa}
// into a larger format without rounding. Every input value, subnormals
// included, is exactly representable in the wider format.
//
// Pipeline: stage 1 registers the input fields, the class and the leading-one
// position of the mantissa. Stage 2 registers the assembled result. A stall
// (output valid but not accepted) freezes both stages.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake
//   Fin, in_tag, ftz     input float, sideband tag, flush-to-zero mode
//   out_valid/out_ready  output handshake
//   Fout, out_tag        widened float and its tag
//   out_flags            {nan, inf, sub, zero} class of the input value
module conv_fp_widen #(
    parameter int EXP_IN  = 5,
    parameter int MAN_IN  = 10,
    parameter int EXP_OUT = 8,
    parameter int MAN_OUT = 23,
    parameter int TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_IN+MAN_IN:0]       Fin,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         ftz,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_OUT+MAN_OUT:0]     Fout,
    output logic [TAG_W-1:0]             out_tag,
    output logic [3:0]                   out_flags
);

    localparam int BIAS_IN   = (1 << (EXP_IN - 1)) - 1;
    localparam int BIAS_OUT  = (1 << (EXP_OUT - 1)) - 1;
    localparam int EXP_DELTA = BIAS_OUT - BIAS_IN;
    // Output exponent of a subnormal whose leading one sits at index 0;
    // each step up in leading-one position adds one.
    localparam int SUB_BASE  = BIAS_OUT + 1 - BIAS_IN - MAN_IN;
    localparam int P_W       = (MAN_IN > 1) ? $clog2(MAN_IN) : 1;
    localparam int PAD       = MAN_OUT - MAN_IN;

    // Handshake: both stages move together unless the output is blocked.
    logic stall;
    logic accept;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: classify and find the leading one.
    // ------------------------------------------------------------------
    logic                 in_sign;
    logic [EXP_IN-1:0]    in_exp;
    logic [MAN_IN-1:0]    in_man;
    logic                 exp_max;
    logic                 exp_min;
    logic                 man_nz;
    logic [3:0]           in_class;
    logic [P_W-1:0]       lead_pos;

    assign in_sign  = Fin[EXP_IN+MAN_IN];
    assign in_exp   = Fin[MAN_IN +: EXP_IN];
    assign in_man   = Fin[MAN_IN-1:0];
    assign exp_max  = &in_exp;
    assign exp_min  = ~|in_exp;
    assign man_nz   = |in_man;
    assign in_class = {exp_max & man_nz, exp_max & ~man_nz,
                       exp_min & man_nz, exp_min & ~man_nz};

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < MAN_IN; i++) begin
            if (in_man[i]) begin
                lead_pos = P_W'(i);
            end
        end
    end

    logic                 s1_valid_reg;
    logic                 s1_sign_reg;
    logic [EXP_IN-1:0]    s1_exp_reg;
    logic [MAN_IN-1:0]    s1_man_reg;
    logic [P_W-1:0]       s1_lead_reg;
    logic [3:0]           s1_class_reg;
    logic                 s1_ftz_reg;
    logic [TAG_W-1:0]     s1_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_exp_reg   <= '0;
            s1_man_reg   <= '0;
            s1_lead_reg  <= '0;
            s1_class_reg <= '0;
            s1_ftz_reg   <= 1'b0;
            s1_tag_reg   <= '0;
        end else if (!stall) begin
            // An idle input cycle becomes a bubble in stage 1.
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sign_reg  <= in_sign;
                s1_exp_reg   <= in_exp;
                s1_man_reg   <= in_man;
                s1_lead_reg  <= lead_pos;
                s1_class_reg <= in_class;
                s1_ftz_reg   <= ftz;
                s1_tag_reg   <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: assemble the wide result.
    // ------------------------------------------------------------------
    logic [MAN_OUT-1:0]       man_wide;
    logic [MAN_IN-1:0]        sub_man;
    logic [EXP_OUT-1:0]       sub_exp;
    logic [EXP_OUT-1:0]       norm_exp;
    logic [EXP_OUT-1:0]       exp_next;
    logic [MAN_OUT-1:0]       man_next;
    logic [EXP_OUT+MAN_OUT:0] fout_next;

    assign man_wide = MAN_OUT'(s1_man_reg) << PAD;
    // Shift the leading one out of the top: the implicit bit of the
    // normalised result. Bits below it become the fraction, left-aligned.
    assign sub_man  = (s1_man_reg << 1) << (P_W'(MAN_IN - 1) - s1_lead_reg);
    assign sub_exp  = EXP_OUT'(SUB_BASE) + EXP_OUT'(s1_lead_reg);
    assign norm_exp = EXP_OUT'(s1_exp_reg) + EXP_OUT'(EXP_DELTA);

    always_comb begin
        exp_next = norm_exp;
        man_next = man_wide;
        if (s1_class_reg[3]) begin
            // NaN: keep the payload, force the quiet bit.
            exp_next = '1;
            man_next = man_wide | (MAN_OUT'(1) << (MAN_OUT - 1));
        end else if (s1_class_reg[2]) begin
            exp_next = '1;
            man_next = '0;
        end else if (s1_class_reg[1]) begin
            if (s1_ftz_reg) begin
                exp_next = '0;
                man_next = '0;
            end else begin
                exp_next = sub_exp;
                man_next = MAN_OUT'(sub_man) << PAD;
            end
        end else if (s1_class_reg[0]) begin
            exp_next = '0;
            man_next = '0;
        end
    end

    assign fout_next = {s1_sign_reg, exp_next, man_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Fout      <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (!stall) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                Fout      <= fout_next;
                out_tag   <= s1_tag_reg;
                out_flags <= s1_class_reg;
            end
        end
    end

endmodule

// File: tb/tb_conv_fp_widen.sv
// Bench for conv_fp_widen (default 16-bit -> 32-bit widths). Expected results
// are queued when a sample is accepted and popped when the output transfers.
// All inputs are driven just after the falling edge; outputs are sampled
// 1 time unit later, well away from the rising edge.
module tb_conv_fp_widen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] fin;
    logic [3:0]  in_tag;
    logic        ftz;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Fout;
    logic [3:0]  out_tag;
    logic [3:0]  out_flags;

    conv_fp_widen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Fin       (fin),
        .in_tag    (in_tag),
        .ftz       (ftz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Fout      (Fout),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic [3:0]  fl;
        logic [3:0]  t;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_stall_cyc = -1;
    int          ready_pct = 100;
    int          stall_cnt = 0;
    int          n_pops = 0;
    bit          hold_pending = 0;
    bit          saw_in_ready_low = 0;
    logic [39:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: normalise a subnormal by shifting until the hidden bit
    // appears, counting the exponent down as it goes.
    function automatic logic [35:0] ref_conv(input logic [15:0] f, input bit z);
        logic        s;
        logic [4:0]  e;
        logic [9:0]  m;
        logic [10:0] mm;
        int          ee;
        s = f[15];
        e = f[14:10];
        m = f[9:0];
        if (e == 5'd31) begin
            if (m == 0) return {4'b0100, s, 8'hFF, 23'd0};
            return {4'b1000, s, 8'hFF, 1'b1, m[8:0], 13'd0};
        end
        if (e == 5'd0) begin
            if (m == 0) return {4'b0001, s, 31'd0};
            if (z)      return {4'b0010, s, 31'd0};
            mm = {1'b0, m};
            ee = -14;
            while (!mm[10]) begin
                mm = mm << 1;
                ee--;
            end
            return {4'b0010, s, 8'(ee + 127), mm[9:0], 13'd0};
        end
        return {4'b0000, s, 8'(int'(e) + 112), m, 13'd0};
    endfunction

    // One clock cycle: drive, settle, then account for the transfers that
    // the coming rising edge will perform.
    task automatic cycle(input bit v, input logic [15:0] f, input bit z, input logic [3:0] t,
                         input bit use_given, input logic [35:0] given, output bit accepted);
        bit          ordy;
        exp_t        e;
        logic [35:0] r;
        @(negedge clk);
        cyc++;
        ordy = (stall_cnt > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
        if (stall_cnt > 0) stall_cnt--;
        in_valid  = v;
        fin       = f;
        ftz       = z;
        in_tag    = t;
        out_ready = ordy;
        #1;
        check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
        if (!in_ready) saw_in_ready_low = 1;
        if (hold_pending && out_valid)
            check("hold", {24'd0, Fout, out_tag, out_flags}, {24'd0, held});
        hold_pending = out_valid && !out_ready;
        held = {Fout, out_tag, out_flags};
        if (!ordy) last_stall_cyc = cyc;
        if (out_valid && out_ready) begin
            n_pops++;
            if (sb_q.size() == 0) begin
                check("spurious", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("fout", {32'd0, Fout}, {32'd0, e.f});
                check("flags", {60'd0, out_flags}, {60'd0, e.fl});
                check("tag", {60'd0, out_tag}, {60'd0, e.t});
                if (e.cyc > last_stall_cyc)
                    check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
        accepted = v && in_ready;
        if (accepted) begin
            r = use_given ? given : ref_conv(f, z);
            e.f = r[31:0];
            e.fl = r[35:32];
            e.t = t;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [15:0] f, input bit z, input logic [3:0] t,
                        input bit use_given, input logic [35:0] given);
        bit acc;
        int budget;
        acc = 0;
        budget = 0;
        while (!acc && budget < 60) begin
            cycle(1'b1, f, z, t, use_given, given, acc);
            budget++;
        end
        if (!acc) check("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 36'd0, acc);
    endtask

    task automatic drain();
        int budget;
        bit acc;
        budget = 0;
        while (sb_q.size() != 0 && budget < 200) begin
            cycle(1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 36'd0, acc);
            budget++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    // Directed vectors: {Fin, ftz, expected {flags, Fout}}.
    logic [15:0] d_fin [12] = '{16'h3C00, 16'hC000, 16'h0200, 16'h0001, 16'h0003, 16'h8001,
                                16'h7C00, 16'hFC00, 16'h7D00, 16'h0000, 16'h8000, 16'h0001};
    bit          d_ftz [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic [35:0] d_exp [12] = '{{4'b0000, 32'h3F800000}, {4'b0000, 32'hC0000000},
                                {4'b0010, 32'h38000000}, {4'b0010, 32'h33800000},
                                {4'b0010, 32'h34400000}, {4'b0010, 32'h80000000},
                                {4'b0100, 32'h7F800000}, {4'b0100, 32'hFF800000},
                                {4'b1000, 32'h7FE00000}, {4'b0001, 32'h00000000},
                                {4'b0001, 32'h80000000}, {4'b0010, 32'h00000000}};
    logic [4:0]  sweep_exp [7] = '{5'd0, 5'd1, 5'd2, 5'd15, 5'd29, 5'd30, 5'd31};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops_before;
        rst_n = 1'b0;
        in_valid = 1'b0;
        fin = '0;
        in_tag = '0;
        ftz = 1'b0;
        out_ready = 1'b1;

        // Reset state.
        idle(3);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_fout", {32'd0, Fout}, 64'd0);
        check("rst_tag", {60'd0, out_tag}, 64'd0);
        check("rst_flags", {60'd0, out_flags}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        idle(1);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Normal, subnormal, ftz and special values, back to back.
        ready_pct = 100;
        for (int i = 0; i < 12; i++) send(d_fin[i], d_ftz[i], 4'(i), 1'b1, d_exp[i]);
        drain();

        // Backpressure: 8 tagged samples with a 5-cycle output stall mid-stream.
        saw_in_ready_low = 0;
        pops_before = n_pops;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) stall_cnt = 5;
            send(16'h3C00 + 16'(i * 16'h0111), 1'b0, 4'(i + 8), 1'b0, 36'd0);
        end
        drain();
        check("bp_in_ready_dropped", {63'd0, saw_in_ready_low}, 64'd1);
        check("bp_count", 64'(n_pops - pops_before), 64'd8);

        // Reset with two samples in flight.
        send(16'h4200, 1'b0, 4'd5, 1'b0, 36'd0);
        send(16'h4400, 1'b0, 4'd6, 1'b0, 36'd0);
        @(posedge clk);
        #2;
        check("inflight_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_fout", {32'd0, Fout}, 64'd0);
        check("async_in_ready", {63'd0, in_ready}, 64'd1);
        sb_q.delete();
        hold_pending = 0;
        idle(2);
        rst_n = 1'b1;
        pops_before = n_pops;
        idle(1);
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        idle(6);
        check("no_ghost_outputs", 64'(n_pops - pops_before), 64'd0);

        // Class-boundary sweep under random output readiness.
        ready_pct = 70;
        for (int z = 0; z < 2; z++) begin
            for (int k = 0; k < 7; k++) begin
                for (int m = 0; m < 1024; m++) begin
                    send({1'($urandom_range(0, 1)), sweep_exp[k], 10'(m)}, z[0], 4'(m), 1'b0, 36'd0);
                end
            end
        end
        for (int i = 0; i < 3000; i++) begin
            send(16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, 36'd0);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
